// File: rtl/adder_pkg.sv
// Shared types for the bit-serial adder: FSM state encoding and default width.
// Imported by the controller; no logic of its own.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } add_state_t;

    localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/serial_adder_seq_if.sv
// Operand/result bundle between the operand source and the serial adder.
// master drives the request side, slave (the adder) drives status and result.
interface serial_adder_seq_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout, ovf
    );

endinterface

// File: rtl/fullAdder1.sv
// 1-bit full-adder cell: purely combinational, zero latency, no flow control.
module fullAdder1 (
    input  logic a,
    input  logic b,
    input  logic Cin,
    output logic sum1,
    output logic Cout
);

    assign sum1 = a ^ b ^ Cin;
    assign Cout = (a & b) | (Cin & (a ^ b));

endmodule

// File: rtl/serial_adder_seq.sv
// Bit-serial WIDTH-bit adder, LSB first through one full-adder cell; done pulses WIDTH+1 cycles after start.
// start is only honoured in IDLE; requests while busy or done are dropped, not queued.
module serial_adder_seq
    import adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_adder_seq_if.slave   bus
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    add_state_t       state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             c_reg_q, c_reg_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic             fa_sum;
    logic             fa_cout;

    fullAdder1 u_fa (
        .a    (a_sr_q[0]),
        .b    (b_sr_q[0]),
        .Cin  (c_reg_q),
        .sum1 (fa_sum),
        .Cout (fa_cout)
    );

    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        c_reg_d = c_reg_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_sr_d  = bus.a;
                    b_sr_d  = bus.b;
                    c_reg_d = bus.cin;
                    cnt_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                sum_d   = {fa_sum, sum_q[WIDTH-1:1]};
                a_sr_d  = a_sr_q >> 1;
                b_sr_d  = b_sr_q >> 1;
                c_reg_d = fa_cout;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    // c_reg_q is still the carry into the MSB here; hold cnt so it never wraps.
                    cout_d  = fa_cout;
                    ovf_d   = c_reg_q ^ fa_cout;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            c_reg_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            c_reg_q <= c_reg_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.busy = (state_q == SHIFT);
    assign bus.done = (state_q == DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder_seq.sv
// Directed bench for the bit-serial adder: vector table, busy-ignore, mid-op reset
// and an exhaustive back-to-back sweep with start held high.
module tb_serial_adder_seq;

    localparam int W = 4;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    serial_adder_seq_if #(.WIDTH(W)) bus ();

    serial_adder_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic [3:0] sum;
        logic       cout;
        logic       ovf;
    } vec_t;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Counts negedges until done is seen (0 on timeout); also counts busy cycles.
    task automatic wait_done(output int cyc, output int busy_cyc);
        cyc      = 0;
        busy_cyc = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            chk("busy_done_overlap", {31'd0, bus.busy & bus.done}, 32'd0);
            if (bus.busy) busy_cyc++;
            if (bus.done) begin
                cyc = k;
                break;
            end
        end
        if (cyc == 0) chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic count_dones(input int n, output int dones);
        dones = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
    endtask

    task automatic do_op(input vec_t v, input string tag);
        int cyc;
        int bc;
        @(negedge clk);
        bus.a     = v.a;
        bus.b     = v.b;
        bus.cin   = v.cin;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        // Scramble operands after capture; the in-flight op must not see them.
        bus.a   = 4'($urandom);
        bus.b   = 4'($urandom);
        bus.cin = 1'($urandom);
        wait_done(cyc, bc);
        chk({tag, "_latency"}, cyc, 32'd5);
        chk({tag, "_busy_cycles"}, bc, 32'd4);
        chk({tag, "_sum"}, {28'd0, bus.sum}, {28'd0, v.sum});
        chk({tag, "_cout"}, {31'd0, bus.cout}, {31'd0, v.cout});
        chk({tag, "_ovf"}, {31'd0, bus.ovf}, {31'd0, v.ovf});
    endtask

    vec_t vecs [9];

    initial begin
        int cyc;
        int bc;
        int dones;
        int n;
        int r;
        int sa;
        int sb;
        logic [3:0] ea;
        logic [3:0] eb;
        logic       ec;
        logic [4:0] er;
        logic       eovf;

        vecs[0] = '{4'h3, 4'h5, 1'b0, 4'h8, 1'b0, 1'b1};
        vecs[1] = '{4'hF, 4'h1, 1'b0, 4'h0, 1'b1, 1'b0};
        vecs[2] = '{4'hF, 4'hF, 1'b1, 4'hF, 1'b1, 1'b0};
        vecs[3] = '{4'h7, 4'h2, 1'b0, 4'h9, 1'b0, 1'b1};
        vecs[4] = '{4'h8, 4'h8, 1'b0, 4'h0, 1'b1, 1'b1};
        vecs[5] = '{4'h0, 4'h0, 1'b1, 4'h1, 1'b0, 1'b0};
        vecs[6] = '{4'hA, 4'h5, 1'b0, 4'hF, 1'b0, 1'b0};
        vecs[7] = '{4'h4, 4'h4, 1'b0, 4'h8, 1'b0, 1'b1};
        vecs[8] = '{4'hC, 4'h7, 1'b1, 4'h4, 1'b1, 1'b0};

        // Reset with garbage on the inputs.
        rst_n     = 1'b0;
        bus.start = 1'($urandom);
        bus.a     = 4'($urandom);
        bus.b     = 4'($urandom);
        bus.cin   = 1'($urandom);
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_sum",  {28'd0, bus.sum},  32'd0);
        chk("rst_cout", {31'd0, bus.cout}, 32'd0);
        chk("rst_ovf",  {31'd0, bus.ovf},  32'd0);
        bus.start = 1'b0;
        rst_n     = 1'b1;

        for (int i = 0; i < 9; i++) begin
            do_op(vecs[i], $sformatf("vec%0d", i));
        end

        // Result must hold in IDLE.
        @(negedge clk);
        @(negedge clk);
        chk("hold_sum", {28'd0, bus.sum}, {28'd0, vecs[8].sum});
        chk("hold_cout", {31'd0, bus.cout}, {31'd0, vecs[8].cout});

        // start during SHIFT cycle 2 is ignored.
        @(negedge clk);
        bus.a = 4'h6; bus.b = 4'h3; bus.cin = 1'b0; bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus.a = 4'h1; bus.b = 4'h1; bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(cyc, bc);
        chk("ign_latency", cyc, 32'd3);
        chk("ign_sum",  {28'd0, bus.sum},  32'h9);
        chk("ign_cout", {31'd0, bus.cout}, 32'd0);
        chk("ign_ovf",  {31'd0, bus.ovf},  32'd1);
        count_dones(10, dones);
        chk("ign_extra_done", dones, 32'd0);
        chk("ign_sum_after", {28'd0, bus.sum}, 32'h9);

        // Reset in SHIFT cycle 2 aborts the op.
        @(negedge clk);
        bus.a = 4'hF; bus.b = 4'hF; bus.cin = 1'b0; bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("mid_rst_done", {31'd0, bus.done}, 32'd0);
        chk("mid_rst_sum",  {28'd0, bus.sum},  32'd0);
        chk("mid_rst_cout", {31'd0, bus.cout}, 32'd0);
        chk("mid_rst_ovf",  {31'd0, bus.ovf},  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        count_dones(10, dones);
        chk("mid_rst_no_done", dones, 32'd0);
        do_op('{4'h7, 4'h2, 1'b0, 4'h9, 1'b0, 1'b1}, "post_rst");

        // Exhaustive sweep, start held high.
        bus.a = 4'h0; bus.b = 4'h0; bus.cin = 1'b0; bus.start = 1'b1;
        for (int i = 0; i < 512; i++) begin
            n  = i;
            ea = 4'(n);
            eb = 4'(n >> 4);
            ec = 1'(n >> 8);
            wait_done(cyc, bc);
            r    = int'(ea) + int'(eb) + int'(ec);
            er   = 5'(r);
            sa   = ea[3] ? int'(ea) - 16 : int'(ea);
            sb   = eb[3] ? int'(eb) - 16 : int'(eb);
            eovf = ((sa + sb + int'(ec)) > 7) || ((sa + sb + int'(ec)) < -8);
            chk($sformatf("exh%0d_sum", i), {27'd0, bus.cout, bus.sum}, {27'd0, er});
            chk($sformatf("exh%0d_ovf", i), {31'd0, bus.ovf}, {31'd0, eovf});
            if (i > 0) chk($sformatf("exh%0d_spacing", i), cyc, 32'd6);
            n = i + 1;
            bus.a   = 4'(n);
            bus.b   = 4'(n >> 4);
            bus.cin = 1'(n >> 8);
        end
        bus.start = 1'b0;
        repeat (10) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
